// File: rtl/decode_output_queue.sv
// In-order show-ahead FIFO between the muxed decoder result bus and rename/dispatch.
// Back-pressure asserts early enough to absorb the decoders' one in-flight result.
module decode_output_queue #(
  parameter int addressWidth            = 64,
  parameter int opcodeSize              = 12,
  parameter int funcUnitCodeSize        = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int regAccessPatternSize    = 2,
  parameter int regSize                 = 5,
  parameter int queueDepth              = 8,
  parameter int stallThreshold          = 2
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic [funcUnitCodeSize-1:0]        functionalUnitType_i,
  input  logic [instructionCounterWidth-1:0] instMajId_i,
  input  logic [instMinIdWidth-1:0]          instMinId_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instPid_i,
  input  logic [TidSize-1:0]                 instTid_i,
  input  logic [regAccessPatternSize-1:0]    op1rw_i,
  input  logic [regAccessPatternSize-1:0]    op2rw_i,
  input  logic [regAccessPatternSize-1:0]    op3rw_i,
  input  logic [regAccessPatternSize-1:0]    op4rw_i,
  input  logic                               op1IsReg_i,
  input  logic                               op2IsReg_i,
  input  logic                               op3IsReg_i,
  input  logic                               op4IsReg_i,
  input  logic [4*regSize:0]                 instructionBody_i,
  output logic                               stall_o,
  input  logic                               ready_i,
  output logic                               enable_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [regAccessPatternSize-1:0]    op1rw_o,
  output logic [regAccessPatternSize-1:0]    op2rw_o,
  output logic [regAccessPatternSize-1:0]    op3rw_o,
  output logic [regAccessPatternSize-1:0]    op4rw_o,
  output logic                               op1IsReg_o,
  output logic                               op2IsReg_o,
  output logic                               op3IsReg_o,
  output logic                               op4IsReg_o,
  output logic [4*regSize:0]                 instructionBody_o,
  output logic [$clog2(queueDepth):0]        count_o,
  output logic                               overflow_o
);

  localparam int bodyWidth  = 4*regSize + 1;
  localparam int ptrWidth   = $clog2(queueDepth);
  localparam int countWidth = ptrWidth + 1;
  localparam int entryWidth = opcodeSize + addressWidth + funcUnitCodeSize
                            + instructionCounterWidth + instMinIdWidth + 1
                            + PidSize + TidSize + 4*regAccessPatternSize + 4
                            + bodyWidth;

  logic [entryWidth-1:0] storage [queueDepth];
  logic [entryWidth-1:0] writeEntry;
  logic [entryWidth-1:0] headEntry;
  logic [ptrWidth-1:0]   rdPtr;
  logic [ptrWidth-1:0]   wrPtr;
  logic [countWidth-1:0] countReg;
  logic                  overflowReg;
  logic                  isEmpty;
  logic                  isFull;
  logic                  doRead;
  logic                  doWrite;

  assign isEmpty = (countReg == '0);
  assign isFull  = (countReg == countWidth'(queueDepth));
  assign doRead  = ready_i && !isEmpty;
  // A read in the same cycle frees the head slot, so a write at full is still accepted.
  assign doWrite = enable_i && (!isFull || doRead);

  assign writeEntry = {opcode_i, instructionAddress_i, functionalUnitType_i,
                       instMajId_i, instMinId_i, is64Bit_i, instPid_i, instTid_i,
                       op1rw_i, op2rw_i, op3rw_i, op4rw_i,
                       op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i,
                       instructionBody_i};

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      countReg    <= '0;
      overflowReg <= 1'b0;
    end else if (flush_i) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      countReg <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      if (doWrite && !doRead)      countReg <= countReg + 1'b1;
      else if (doRead && !doWrite) countReg <= countReg - 1'b1;
      if (enable_i && !doWrite) overflowReg <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (doWrite && !flush_i) storage[wrPtr] <= writeEntry;
  end

  // Payload is zeroed while empty so stale storage never leaks to dispatch.
  assign headEntry = isEmpty ? '0 : storage[rdPtr];

  assign {opcode_o, instructionAddress_o, functionalUnitType_o,
          instMajId_o, instMinId_o, is64Bit_o, instPid_o, instTid_o,
          op1rw_o, op2rw_o, op3rw_o, op4rw_o,
          op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
          instructionBody_o} = headEntry;

  assign enable_o   = !isEmpty;
  assign count_o    = countReg;
  assign overflow_o = overflowReg;
  assign stall_o    = (queueDepth - int'(countReg)) <= stallThreshold;

endmodule

// File: tb/tb_decode_output_queue.sv
// Bench for decode_output_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_decode_output_queue;

  localparam int depth = 8;

  typedef struct packed {
    logic [11:0] opcode;
    logic [63:0] addr;
    logic [2:0]  fu;
    logic [63:0] majId;
    logic [6:0]  minId;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [1:0]  rw1, rw2, rw3, rw4;
    logic        reg1, reg2, reg3, reg4;
    logic [20:0] body;
  } payload_t;

  typedef struct {
    bit          en;
    bit          rdy;
    logic [63:0] id;
    int          expCount;
    bit          expEn;
    bit          expStall;
    bit          expOvf;
    logic [63:0] expHead;
  } vec_t;

  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  logic flush_i = 1'b0;
  logic enable_i = 1'b0;
  logic ready_i = 1'b0;
  payload_t inPay = '0;
  payload_t actPay;
  logic stall_o, enable_o, overflow_o;
  logic [3:0] count_o;

  logic [11:0] opcode_o;
  logic [63:0] instructionAddress_o, instMajId_o;
  logic [2:0]  functionalUnitType_o;
  logic [6:0]  instMinId_o;
  logic        is64Bit_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic [19:0] instPid_o;
  logic [15:0] instTid_o;
  logic [1:0]  op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic [20:0] instructionBody_o;

  always #5 clock_i = ~clock_i;

  decode_output_queue dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
    .opcode_i(inPay.opcode), .instructionAddress_i(inPay.addr),
    .functionalUnitType_i(inPay.fu), .instMajId_i(inPay.majId),
    .instMinId_i(inPay.minId), .is64Bit_i(inPay.is64),
    .instPid_i(inPay.pid), .instTid_i(inPay.tid),
    .op1rw_i(inPay.rw1), .op2rw_i(inPay.rw2), .op3rw_i(inPay.rw3), .op4rw_i(inPay.rw4),
    .op1IsReg_i(inPay.reg1), .op2IsReg_i(inPay.reg2),
    .op3IsReg_i(inPay.reg3), .op4IsReg_i(inPay.reg4),
    .instructionBody_i(inPay.body),
    .stall_o(stall_o), .ready_i(ready_i), .enable_o(enable_o),
    .opcode_o(opcode_o), .instructionAddress_o(instructionAddress_o),
    .functionalUnitType_o(functionalUnitType_o), .instMajId_o(instMajId_o),
    .instMinId_o(instMinId_o), .is64Bit_o(is64Bit_o),
    .instPid_o(instPid_o), .instTid_o(instTid_o),
    .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
    .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o),
    .op3IsReg_o(op3IsReg_o), .op4IsReg_o(op4IsReg_o),
    .instructionBody_o(instructionBody_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  assign actPay = {opcode_o, instructionAddress_o, functionalUnitType_o, instMajId_o,
                   instMinId_o, is64Bit_o, instPid_o, instTid_o,
                   op1rw_o, op2rw_o, op3rw_o, op4rw_o,
                   op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, instructionBody_o};

  int passCount = 0;
  int totalCount = 0;
  payload_t modelQ[$];
  bit modelOvf = 1'b0;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic payload_t randPay(input logic [63:0] id);
    payload_t p;
    p.opcode = 12'($urandom);
    p.addr   = {$urandom, $urandom};
    p.fu     = 3'($urandom);
    p.majId  = id;
    p.minId  = 7'($urandom);
    p.is64   = 1'($urandom);
    p.pid    = 20'($urandom);
    p.tid    = 16'($urandom);
    {p.rw1, p.rw2, p.rw3, p.rw4} = 8'($urandom);
    {p.reg1, p.reg2, p.reg3, p.reg4} = 4'($urandom);
    p.body   = 21'($urandom);
    return p;
  endfunction

  // Reference: a plain FIFO of payloads with depth-limited acceptance.
  task automatic modelEdge(input bit en, input bit rdy, input bit fl, input payload_t p);
    int pre;
    bit rd;
    pre = modelQ.size();
    rd  = rdy && (pre > 0);
    if (fl) modelQ.delete();
    else begin
      if (rd) void'(modelQ.pop_front());
      if (en) begin
        if (pre < depth || rd) modelQ.push_back(p);
        else modelOvf = 1'b1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    payload_t expPay;
    int n;
    n = modelQ.size();
    expPay = (n > 0) ? modelQ[0] : '0;
    chk({tag, ".count"}, 256'(count_o), 256'(n));
    chk({tag, ".enable"}, 256'(enable_o), 256'(n > 0));
    chk({tag, ".stall"}, 256'(stall_o), 256'((depth - n) <= 2));
    chk({tag, ".overflow"}, 256'(overflow_o), 256'(modelOvf));
    chk({tag, ".payload"}, 256'(actPay), 256'(expPay));
  endtask

  task automatic cycle(input bit en, input bit rdy, input bit fl, input payload_t p);
    enable_i = en;
    ready_i  = rdy;
    flush_i  = fl;
    inPay    = p;
    modelEdge(en, rdy, fl, p);
    @(posedge clock_i);
    #1;
  endtask

  task automatic doReset();
    reset_i = 1'b0;
    enable_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
  endtask

  initial begin
    payload_t p;
    logic [63:0] popped[$];
    int nextId;
    int guard;

    for (int i = 0; i < 9; i++) begin
      int c;
      c = (i + 1 > depth) ? depth : i + 1;
      vecs[i] = '{en: 1'b1, rdy: 1'b0, id: 64'(i), expCount: c, expEn: 1'b1,
                  expStall: (c >= 6), expOvf: (i == 8), expHead: 64'd0};
    end
    for (int j = 0; j < 8; j++) begin
      int c;
      c = 7 - j;
      vecs[9 + j] = '{en: 1'b0, rdy: 1'b1, id: 64'd0, expCount: c, expEn: (c > 0),
                      expStall: (c >= 6), expOvf: 1'b1,
                      expHead: (c > 0) ? 64'(j + 1) : 64'd0};
    end

    // Reset state while reset is held
    @(posedge clock_i);
    #1;
    checkAll("reset");
    doReset();
    checkAll("postReset");

    // Single pass-through: visible exactly one edge after the write
    p = randPay(64'd5);
    p.opcode = 12'h0A1;
    chk("pass.preEnable", 256'(enable_o), 256'(0));
    cycle(1'b1, 1'b1, 1'b0, p);
    chk("pass.enable", 256'(enable_o), 256'(1));
    chk("pass.majId", 256'(instMajId_o), 256'(5));
    chk("pass.opcode", 256'(opcode_o), 256'(12'h0A1));
    checkAll("pass");
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("pass.drained", 256'(count_o), 256'(0));

    // Table: fill to full, overflow on 9th, drain in order
    for (int k = 0; k < 17; k++) begin
      cycle(vecs[k].en, vecs[k].rdy, 1'b0, randPay(vecs[k].id));
      chk($sformatf("vec%0d.count", k), 256'(count_o), 256'(vecs[k].expCount));
      chk($sformatf("vec%0d.enable", k), 256'(enable_o), 256'(vecs[k].expEn));
      chk($sformatf("vec%0d.stall", k), 256'(stall_o), 256'(vecs[k].expStall));
      chk($sformatf("vec%0d.overflow", k), 256'(overflow_o), 256'(vecs[k].expOvf));
      chk($sformatf("vec%0d.head", k), 256'(instMajId_o), 256'(vecs[k].expHead));
      checkAll($sformatf("vec%0d", k));
    end

    // Full plus simultaneous read and write
    doReset();
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b0, randPay(64'(k)));
    cycle(1'b1, 1'b1, 1'b0, randPay(64'd8));
    chk("fullRw.count", 256'(count_o), 256'(8));
    chk("fullRw.overflow", 256'(overflow_o), 256'(0));
    chk("fullRw.head", 256'(instMajId_o), 256'(1));
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("fullRw.order%0d", k), 256'(instMajId_o), 256'(k));
      cycle(1'b0, 1'b1, 1'b0, '0);
    end
    checkAll("fullRw.end");

    // Asynchronous reset mid-stream with 3 entries held
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, randPay(64'(40 + k)));
    chk("midRst.pre", 256'(count_o), 256'(3));
    reset_i = 1'b0;
    #1;
    modelQ.delete();
    modelOvf = 1'b0;
    chk("midRst.enable", 256'(enable_o), 256'(0));
    chk("midRst.count", 256'(count_o), 256'(0));
    chk("midRst.stall", 256'(stall_o), 256'(0));
    chk("midRst.payload", 256'(actPay), 256'(0));
    @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, '0);
    checkAll("midRst.after");

    // Wrap: 20 entries with random ready, strictly in order
    nextId = 0;
    guard = 0;
    popped.delete();
    while (popped.size() < 20 && guard < 500) begin
      bit en, rdy;
      rdy = 1'($urandom_range(0, 1));
      en  = (nextId < 20) && (modelQ.size() < 6) && ($urandom_range(0, 1) == 1);
      if (enable_o && rdy) popped.push_back(instMajId_o);
      cycle(en, rdy, 1'b0, randPay(64'(nextId)));
      if (en) nextId++;
      checkAll("wrap");
      guard++;
    end
    chk("wrap.received", 256'(popped.size()), 256'(20));
    for (int k = 0; k < popped.size(); k++)
      chk($sformatf("wrap.id%0d", k), 256'(popped[k]), 256'(k));

    // Flush with 4 entries and a same-cycle write
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, randPay(64'(60 + k)));
    chk("flush.pre", 256'(count_o), 256'(4));
    cycle(1'b1, 1'b1, 1'b1, randPay(64'd99));
    chk("flush.count", 256'(count_o), 256'(0));
    chk("flush.enable", 256'(enable_o), 256'(0));
    cycle(1'b1, 1'b0, 1'b0, randPay(64'd77));
    chk("flush.alone", 256'(count_o), 256'(1));
    chk("flush.head", 256'(instMajId_o), 256'(77));
    checkAll("flush");

    // Randomized traffic including overflow and occasional flush
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 29) == 0), randPay(64'(1000 + k)));
      checkAll("rand");
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
